// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN    = 32'h8000_0000;

    // RV32M funct3 encodings; bit 2 separates divide from multiply,
    // bit 1 within the divide group selects the remainder.
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage request/response bundle between the issue logic and the
// multiply/divide unit.
interface muldiv_if;
    import muldiv_pkg::*;

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, funct3, operand_a, operand_b, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, funct3, operand_a, operand_b, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_div_core.sv
// Restoring divider datapath on unsigned magnitudes: one quotient bit per
// step. The dividend is shifted out of the quotient register MSB-first while
// quotient bits are shifted in at the LSB. The next-state values are exported
// so the parent can capture the final result on the last step's edge.
module muldiv_div_core
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quot_next,
    output logic [XLEN-1:0] rem_next
);

    logic [XLEN-1:0] quot_reg;
    logic [XLEN-1:0] rem_reg;
    logic [XLEN-1:0] divisor_reg;

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          fits;

    // Trial subtraction of the divisor from the partial remainder.
    assign shifted  = {rem_reg, quot_reg[XLEN-1]};
    assign diff     = shifted - {1'b0, divisor_reg};
    assign fits     = ~diff[XLEN];
    assign rem_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];

    assign quot_next[0] = fits;
    generate
        for (genvar gi = 1; gi < XLEN; gi++) begin : g_quot_shift
            assign quot_next[gi] = quot_reg[gi-1];
        end
    endgenerate

    // Load fresh operands on accept, otherwise advance one step when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_reg    <= '0;
            rem_reg     <= '0;
            divisor_reg <= '0;
        end else if (load) begin
            quot_reg    <= dividend;
            rem_reg     <= '0;
            divisor_reg <= divisor;
        end else if (step) begin
            quot_reg    <= quot_next;
            rem_reg     <= rem_next;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes
// at accept time, processed by a shift-add multiplier or the restoring
// divider, and the sign is reapplied when the result is captured.
// Build option: define MULDIV_FAST_MUL_EN to replace the iterative
// multiplier with a single-cycle one (one CALC cycle for multiply ops).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

    state_e              state_reg;
    op_e                 op_reg;
    logic [4:0]          rd_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [XLEN-1:0]     a_mag_reg;
    logic [2*XLEN-1:0]   prod_reg;
    logic                neg_reg;
    logic                rem_neg_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [XLEN-1:0]     result_reg;

    // ---- request decode -------------------------------------------------
    op_e             op_in;
    logic            a_signed, b_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] special_res;
    logic            accept;

    assign op_in    = op_e'(bus.funct3);
    assign a_signed = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign b_signed = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    assign a_neg    = a_signed & bus.operand_a[XLEN-1];
    assign b_neg    = b_signed & bus.operand_b[XLEN-1];
    assign a_mag    = a_neg ? -bus.operand_a : bus.operand_a;
    assign b_mag    = b_neg ? -bus.operand_b : bus.operand_b;
    assign div_zero = bus.funct3[2] && (bus.operand_b == '0);
    assign div_ovf  = (op_in inside {OP_DIV, OP_REM}) &&
                      (bus.operand_a == INT_MIN) && (bus.operand_b == '1);
    assign accept   = (state_reg == IDLE) && bus.start;

    // Results for the cases that never enter the iterative datapath.
    always_comb begin
        special_res = DIV_ZERO_Q;
        if (div_ovf)
            special_res = bus.funct3[1] ? '0 : INT_MIN;
        else if (bus.funct3[1])
            special_res = bus.operand_a;
    end

    // ---- multiplier -----------------------------------------------------
    logic [2*XLEN-1:0] prod_next;
    logic              last_iter;

`ifdef MULDIV_FAST_MUL_EN
    // The magnitude of b sits in the low half of prod_reg after accept.
    assign prod_next = {{XLEN{1'b0}}, a_mag_reg} * {{XLEN{1'b0}}, prod_reg[XLEN-1:0]};
    assign last_iter = (cnt_reg == CNT_W'(XLEN-1)) || !op_reg[2];
`else
    // Add a into the upper half when the current multiplier bit is set,
    // then shift the whole accumulator right, consuming b from the bottom.
    logic [XLEN:0] mul_sum;
    assign mul_sum   = {1'b0, prod_reg[2*XLEN-1:XLEN]} +
                       (prod_reg[0] ? {1'b0, a_mag_reg} : '0);
    assign prod_next = {mul_sum, prod_reg[XLEN-1:1]};
    assign last_iter = (cnt_reg == CNT_W'(XLEN-1));
`endif

    // ---- divider --------------------------------------------------------
    logic [XLEN-1:0] quot_next, rem_next;

    muldiv_div_core u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .step      (state_reg == CALC),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quot_next (quot_next),
        .rem_next  (rem_next)
    );

    // ---- sign restore and result select ---------------------------------
    logic [2*XLEN-1:0] prod_final;
    logic [XLEN-1:0]   quot_final, rem_final, calc_res;

    assign prod_final = neg_reg     ? -prod_next : prod_next;
    assign quot_final = neg_reg     ? -quot_next : quot_next;
    assign rem_final  = rem_neg_reg ? -rem_next  : rem_next;

    // Pick the architectural result for the op captured at accept.
    always_comb begin
        calc_res = prod_final[XLEN-1:0];
        case (op_reg)
            OP_MUL:                      calc_res = prod_final[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_final[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             calc_res = quot_final;
            OP_REM, OP_REMU:             calc_res = rem_final;
            default:                     calc_res = prod_final[XLEN-1:0];
        endcase
    end

    // Control FSM with registered busy/done/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            op_reg      <= OP_MUL;
            rd_reg      <= '0;
            cnt_reg     <= '0;
            a_mag_reg   <= '0;
            prod_reg    <= '0;
            neg_reg     <= 1'b0;
            rem_neg_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            result_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        op_reg      <= op_in;
                        rd_reg      <= bus.rd_in;
                        a_mag_reg   <= a_mag;
                        prod_reg    <= {{XLEN{1'b0}}, b_mag};
                        neg_reg     <= a_neg ^ b_neg;
                        rem_neg_reg <= a_neg;
                        cnt_reg     <= '0;
                        busy_reg    <= 1'b1;
                        if (div_zero || div_ovf) begin
                            state_reg  <= DONE;
                            done_reg   <= 1'b1;
                            result_reg <= special_res;
                        end else begin
                            state_reg  <= CALC;
                        end
                    end
                end
                CALC: begin
                    prod_reg <= prod_next;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (last_iter) begin
                        state_reg  <= DONE;
                        done_reg   <= 1'b1;
                        result_reg <= calc_res;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.result = result_reg;
    assign bus.rd_out = rd_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: one line per transaction, one summary line.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    muldiv_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;
    localparam int SPC_LAT = 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Issue one op, measure start-to-done edges and check the response.
    // With intrude set, a second conflicting start is driven during CALC.
    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res,
                          input int exp_lat, input bit intrude);
        int lat;
        bit busy_ok;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.funct3    = f3;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.rd_in     = rd;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!bus.done && lat < 100) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (intrude && lat == 5) begin
                bus.start     = 1'b1;
                bus.funct3    = 3'b000;
                bus.operand_a = 32'd6;
                bus.operand_b = 32'd7;
                bus.rd_in     = 5'd9;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        check({tag, ".done"},    {31'd0, bus.done}, 32'd1);
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".result"},  bus.result, exp_res);
        check({tag, ".rd_out"},  {27'd0, bus.rd_out}, {27'd0, rd});
        check({tag, ".busy"},    {31'd0, busy_ok & bus.busy}, 32'd1);
        $display("op %-8s f3=%b a=%h b=%h rd=%0d -> result=%h rd_out=%0d latency=%0d",
                 tag, f3, a, b, rd, bus.result, bus.rd_out, lat);
        @(posedge clk); #1;
        check({tag, ".done_drop"}, {31'd0, bus.done}, 32'd0);
        check({tag, ".busy_drop"}, {31'd0, bus.busy}, 32'd0);
        check({tag, ".held"},      bus.result, exp_res);
    endtask

    initial begin
        bit seen;
        bus.start     = 1'b0;
        bus.funct3    = 3'b000;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.rd_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy",   {31'd0, bus.busy}, 32'd0);
        check("reset.done",   {31'd0, bus.done}, 32'd0);
        check("reset.result", bus.result, 32'd0);
        check("reset.rd_out", {27'd0, bus.rd_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("MUL",    3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_LAT, 1'b0);
        run_op("MULH",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000, MUL_LAT, 1'b0);
        run_op("MULHU",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, MUL_LAT, 1'b0);
        run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, MUL_LAT, 1'b0);
        run_op("MULHU2", 3'b011, 32'h8000_0000, 32'd2,         5'd9,  32'h0000_0001, MUL_LAT, 1'b0);
        run_op("MULx0",  3'b000, 32'd6,         32'd7,         5'd0,  32'd42,        MUL_LAT, 1'b0);
        run_op("DIV",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, DIV_LAT, 1'b0);
        run_op("REM",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, DIV_LAT, 1'b0);
        run_op("DIVU",   3'b101, 32'd100,       32'd7,         5'd12, 32'd14,        DIV_LAT, 1'b0);
        run_op("REMU",   3'b111, 32'd100,       32'd7,         5'd13, 32'd2,         DIV_LAT, 1'b0);
        run_op("DIVneg", 3'b100, 32'd20,        32'hFFFF_FFFB, 5'd14, 32'hFFFF_FFFC, DIV_LAT, 1'b0);
        run_op("DIVz",   3'b100, 32'd5,         32'd0,         5'd15, 32'hFFFF_FFFF, SPC_LAT, 1'b0);
        run_op("REMUz",  3'b111, 32'd5,         32'd0,         5'd16, 32'd5,         SPC_LAT, 1'b0);
        run_op("REMz",   3'b110, 32'hFFFF_FFFB, 32'd0,         5'd17, 32'hFFFF_FFFB, SPC_LAT, 1'b0);
        run_op("DIVovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, SPC_LAT, 1'b0);
        run_op("REMovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h0000_0000, SPC_LAT, 1'b0);
        run_op("DIVUbsy",3'b101, 32'd100,       32'd7,         5'd3,  32'd14,        DIV_LAT, 1'b1);

        // Abort a divide mid-CALC with an asynchronous reset.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.funct3    = 3'b101;
        bus.operand_a = 32'd1000;
        bus.operand_b = 32'd3;
        bus.rd_in     = 5'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.busy",   {31'd0, bus.busy}, 32'd0);
        check("rst.done",   {31'd0, bus.done}, 32'd0);
        check("rst.result", bus.result, 32'd0);
        check("rst.rd_out", {27'd0, bus.rd_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("rst.no_done", {31'd0, seen}, 32'd0);
        $display("op reset   mid-CALC abort -> busy=%0d done=%0d result=%h", bus.busy, bus.done, bus.result);

        run_op("DIVpost", 3'b100, 32'd1000, 32'd3, 5'd21, 32'd333, DIV_LAT, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
